// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit user interface between several requesters.
// A grant is held for a whole packet, or until P_MAX_BEATS beats have been sent.
module uart_tx_arbiter #(
    parameter int unsigned P_REQ_NUM    = 4,
    parameter int unsigned P_DATA_WIDTH = 8,
    parameter int unsigned P_MAX_BEATS  = 16
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic [P_REQ_NUM*P_DATA_WIDTH-1:0] i_req_data,
    input  logic [P_REQ_NUM-1:0]              i_req_valid,
    input  logic [P_REQ_NUM-1:0]              i_req_last,
    output logic [P_REQ_NUM-1:0]              o_req_ready,
    output logic [P_DATA_WIDTH-1:0]           o_tx_data,
    output logic                              o_tx_valid,
    input  logic                              i_tx_ready,
    output logic [P_REQ_NUM-1:0]              o_grant,
    output logic                              o_busy,
    output logic                              o_trunc
);

    localparam int unsigned IdxW = $clog2(P_REQ_NUM);
    localparam int unsigned CntW = $clog2(P_MAX_BEATS + 1);

    typedef enum logic {StIdle, StXfer} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] gidx_q, gidx_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            trunc_q, trunc_d;
    logic [IdxW-1:0] pick_idx;
    logic            pick_found;
    logic            fire;
    logic            beat_last;
    logic            beat_max;

    // gidx_q doubles as the last-granted index while idle.
    always_comb begin
        int unsigned k;
        logic [IdxW-1:0] kk;
        k          = 0;
        kk         = '0;
        pick_found = 1'b0;
        pick_idx   = gidx_q;
        for (int unsigned i = 1; i <= P_REQ_NUM; i++) begin
            k  = (32'(gidx_q) + i) % P_REQ_NUM;
            kk = IdxW'(k);
            if (!pick_found && i_req_valid[kk]) begin
                pick_found = 1'b1;
                pick_idx   = kk;
            end
        end
    end

    always_comb begin
        o_grant     = '0;
        o_req_ready = '0;
        o_tx_data   = '0;
        o_tx_valid  = 1'b0;
        if (state_q == StXfer) begin
            o_grant[gidx_q]     = 1'b1;
            o_req_ready[gidx_q] = i_tx_ready;
            o_tx_data           = i_req_data[gidx_q*P_DATA_WIDTH +: P_DATA_WIDTH];
            o_tx_valid          = i_req_valid[gidx_q];
        end
    end

    assign o_busy    = (state_q == StXfer);
    assign o_trunc   = trunc_q;
    assign fire      = o_tx_valid & i_tx_ready;
    assign beat_last = i_req_last[gidx_q];
    assign beat_max  = (cnt_q == CntW'(P_MAX_BEATS - 1));

    always_comb begin
        state_d = state_q;
        gidx_d  = gidx_q;
        cnt_d   = cnt_q;
        trunc_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    gidx_d  = pick_idx;
                    cnt_d   = '0;
                    state_d = StXfer;
                end
            end
            StXfer: begin
                if (fire) begin
                    if (beat_last || beat_max) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                        trunc_d = ~beat_last;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
            gidx_q  <= IdxW'(P_REQ_NUM - 1);
            cnt_q   <= '0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gidx_q  <= gidx_d;
            cnt_q   <= cnt_d;
            trunc_q <= trunc_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (4 requesters, 8-bit data, 16-beat limit).
module tb_uart_tx_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           i_clk = 1'b0;
    logic           i_rst = 1'b1;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_last;
    logic [N-1:0]   o_req_ready;
    logic [W-1:0]   o_tx_data;
    logic           o_tx_valid;
    logic           tx_ready;
    logic [N-1:0]   o_grant;
    logic           o_busy;
    logic           o_trunc;

    uart_tx_arbiter #(
        .P_REQ_NUM   (N),
        .P_DATA_WIDTH(W),
        .P_MAX_BEATS (16)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_req_data (req_data),
        .i_req_valid(req_valid),
        .i_req_last (req_last),
        .o_req_ready(o_req_ready),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .i_tx_ready (tx_ready),
        .o_grant    (o_grant),
        .o_busy     (o_busy),
        .o_trunc    (o_trunc)
    );

    always #5 i_clk = ~i_clk;

    // Per-requester beat sources: {last, data} FIFOs.
    logic [8:0] mem [N][64];
    int         head [N];
    int         tail [N];
    logic [N-1:0] hold = '0;

    always_comb begin
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        for (int k = 0; k < N; k++) begin
            req_valid[k]      = (head[k] != tail[k]) && !hold[k];
            req_data[k*W +: W] = mem[k][head[k] % 64][7:0];
            req_last[k]       = mem[k][head[k] % 64][8];
        end
    end

    always @(posedge i_clk) begin
        for (int k = 0; k < N; k++)
            if (req_valid[k] && o_req_ready[k]) head[k] <= head[k] + 1;
    end

    logic rdy_toggle = 1'b0;
    logic tog_q = 1'b0;
    always @(posedge i_clk) tog_q <= ~tog_q;
    assign tx_ready = rdy_toggle ? tog_q : 1'b1;

    // Transfer monitor, sampled mid-cycle.
    logic [7:0] sent [$];
    int         fire_cyc [$];
    int         cyc_n = 0;
    int         trunc_cnt = 0;
    always @(posedge i_clk) cyc_n <= cyc_n + 1;
    always @(negedge i_clk) begin
        if (!i_rst && o_tx_valid && tx_ready) begin
            sent.push_back(o_tx_data);
            fire_cyc.push_back(cyc_n);
        end
        if (!i_rst && o_trunc) trunc_cnt <= trunc_cnt + 1;
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push(input int k, input logic [7:0] d, input logic l);
        mem[k][tail[k] % 64] = {l, d};
        tail[k]++;
    endtask

    function automatic logic all_empty();
        logic e;
        e = 1'b1;
        for (int k = 0; k < N; k++) if (head[k] != tail[k]) e = 1'b0;
        return e;
    endfunction

    task automatic do_reset();
        i_rst = 1'b1;
        cyc();
        cyc();
        for (int k = 0; k < N; k++) tail[k] = head[k];
        hold  = '0;
        i_rst = 1'b0;
        cyc();
    endtask

    task automatic drain(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (all_empty() && !o_busy) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
        check(tag, {31'd0, ok}, 32'd1);
        cyc();
    endtask

    task automatic wait_sent(input string tag, input int n);
        for (int i = 0; i < 200 && sent.size() < n; i++) cyc();
        check(tag, {31'd0, sent.size() >= n}, 32'd1);
    endtask

    int b;
    int t0;

    initial begin
        // Reset state
        #1;
        check("rst_grant", 32'(o_grant), 32'h0);
        check("rst_busy", 32'(o_busy), 32'h0);
        check("rst_valid", 32'(o_tx_valid), 32'h0);
        check("rst_data", 32'(o_tx_data), 32'h0);
        check("rst_ready", 32'(o_req_ready), 32'h0);
        check("rst_trunc", 32'(o_trunc), 32'h0);
        do_reset();

        // Single 3-beat packet with a toggling UART ready
        rdy_toggle = 1'b1;
        b  = sent.size();
        t0 = trunc_cnt;
        push(0, 8'h11, 1'b0);
        push(0, 8'h22, 1'b0);
        push(0, 8'h33, 1'b1);
        #1;
        check("t1_grant_lat0", 32'(o_grant), 32'h0);
        cyc();
        check("t1_grant", 32'(o_grant), 32'h1);
        check("t1_busy", 32'(o_busy), 32'h1);
        drain("t1_drain");
        check("t1_d0", 32'(sent[b]), 32'h11);
        check("t1_d1", 32'(sent[b+1]), 32'h22);
        check("t1_d2", 32'(sent[b+2]), 32'h33);
        check("t1_cnt", 32'(sent.size() - b), 32'd3);
        check("t1_idle", 32'(o_grant), 32'h0);
        check("t1_trunc", 32'(trunc_cnt - t0), 32'd0);
        rdy_toggle = 1'b0;

        // All four valid with 1-beat packets: strict rotation, one bubble between grants
        do_reset();
        b = sent.size();
        push(0, 8'hA0, 1'b1);
        push(0, 8'hA0, 1'b1);
        push(1, 8'hA1, 1'b1);
        push(2, 8'hA2, 1'b1);
        push(3, 8'hA3, 1'b1);
        drain("t2_drain");
        check("t2_o0", 32'(sent[b]), 32'hA0);
        check("t2_o1", 32'(sent[b+1]), 32'hA1);
        check("t2_o2", 32'(sent[b+2]), 32'hA2);
        check("t2_o3", 32'(sent[b+3]), 32'hA3);
        check("t2_o4", 32'(sent[b+4]), 32'hA0);
        for (int i = 0; i < 4; i++)
            check("t2_gap", 32'(fire_cyc[b+i+1] - fire_cyc[b+i]), 32'd2);

        // req2 served, then req1 and req3 together: req3 first
        do_reset();
        b = sent.size();
        push(2, 8'hC2, 1'b1);
        drain("t3_drain0");
        push(1, 8'hB1, 1'b1);
        push(3, 8'hB3, 1'b1);
        drain("t3_drain1");
        check("t3_first", 32'(sent[b]), 32'hC2);
        check("t3_r3", 32'(sent[b+1]), 32'hB3);
        check("t3_r1", 32'(sent[b+2]), 32'hB1);

        // 20 beats without last until the end: forced release after 16
        do_reset();
        b  = sent.size();
        t0 = trunc_cnt;
        for (int i = 0; i < 20; i++) push(1, 8'(8'h40 + i), (i == 19));
        drain("t4_drain");
        check("t4_cnt", 32'(sent.size() - b), 32'd20);
        check("t4_b15", 32'(sent[b+15]), 32'h4F);
        check("t4_b19", 32'(sent[b+19]), 32'h53);
        check("t4_trunc", 32'(trunc_cnt - t0), 32'd1);
        check("t4_gap_in", 32'(fire_cyc[b+15] - fire_cyc[b+14]), 32'd1);
        check("t4_gap_rel", 32'(fire_cyc[b+16] - fire_cyc[b+15]), 32'd2);

        // Asynchronous reset mid-packet
        do_reset();
        b = sent.size();
        for (int i = 0; i < 5; i++) push(0, 8'(8'h60 + i), (i == 4));
        wait_sent("t5_wait", b + 2);
        check("t5_pre_grant", 32'(o_grant), 32'h1);
        i_rst = 1'b1;
        #1;
        check("t5_valid", 32'(o_tx_valid), 32'h0);
        check("t5_grant", 32'(o_grant), 32'h0);
        check("t5_ready", 32'(o_req_ready), 32'h0);
        check("t5_cnt", 32'(sent.size() - b), 32'd2);
        do_reset();
        b = sent.size();
        push(3, 8'hD3, 1'b1);
        push(0, 8'hD0, 1'b1);
        drain("t5_drain");
        check("t5_r0", 32'(sent[b]), 32'hD0);
        check("t5_r3", 32'(sent[b+1]), 32'hD3);

        // Granted requester stalls mid-packet; grant is held
        do_reset();
        b = sent.size();
        push(2, 8'hE0, 1'b0);
        push(2, 8'hE1, 1'b0);
        push(2, 8'hE2, 1'b1);
        wait_sent("t6_wait", b + 1);
        hold[2] = 1'b1;
        push(0, 8'hF0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("t6_hold_grant", 32'(o_grant), 32'h4);
        end
        check("t6_hold_cnt", 32'(sent.size() - b), 32'd1);
        hold[2] = 1'b0;
        drain("t6_drain");
        check("t6_e1", 32'(sent[b+1]), 32'hE1);
        check("t6_e2", 32'(sent[b+2]), 32'hE2);
        check("t6_f0", 32'(sent[b+3]), 32'hF0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
